vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised, two-mode VGA raster timing generator. It succeeds the fixed 640x480 controller. It produces pixel coordinates, sync, display-enable and frame/line markers for the pixel pipeline on the Nexys3 (Spartan-6). It adds a runtime mode select that takes effect only at a frame boundary, per-mode sync polarity, a clock-enable input for divided pixel rates, and exact 0..TOTAL-1 counting. All outputs are registered and mutually aligned.

## Interface
- CW, 11, width of hcount/vcount; must hold H_TOTAL-1 and V_TOTAL-1 of both modes
- H_ACT0 / H_FP0 / H_SYNC0 / H_BP0, 640 / 16 / 96 / 48, mode-0 horizontal active, front porch, sync and back porch in pixels
- V_ACT0 / V_FP0 / V_SYNC0 / V_BP0, 480 / 10 / 2 / 33, mode-0 vertical timing in lines
- HS_POL0 / VS_POL0, 0 / 0, mode-0 sync active level (0 = active-low)
- H_ACT1 / H_FP1 / H_SYNC1 / H_BP1, 800 / 40 / 128 / 88, mode-1 horizontal timing
- V_ACT1 / V_FP1 / V_SYNC1 / V_BP1, 600 / 1 / 4 / 23, mode-1 vertical timing
- HS_POL1 / VS_POL1, 1 / 1, mode-1 sync active level
- pixel_clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  pixel advance strobe; all registers hold when low
- mode_sel  in  1  requested timing set, sampled at frame boundary
- mode  out  1  timing set currently in force
- hcount  out  CW  current pixel column
- vcount  out  CW  current line
- hs  out  1  horizontal sync, polarity per mode
- vs  out  1  vertical sync, polarity per mode
- de  out  1  high when hcount < H_ACT and vcount < V_ACT
- blank  out  1  exact complement of de
- line_start  out  1  high while hcount == 0
- frame_start  out  1  high while hcount == 0 and vcount == 0

## Operation
- Totals: H_TOTAL = ACT+FP+SYNC+BP and V_TOTAL likewise, both for the current mode. Mode 0 is 800x525; mode 1 is 1056x628.
- hcount counts 0..H_TOTAL-1 and wraps to 0. vcount increments on each h wrap and wraps to 0 after V_TOTAL-1. Counters never reach TOTAL.
- Horizontal regions: active [0, H_ACT), front porch [H_ACT, H_ACT+FP), sync [H_ACT+FP, H_ACT+FP+SYNC), back porch up to H_TOTAL-1. Vertical regions are identical in form.
- hs equals POL during the sync region and ~POL otherwise; vs follows the same rule.
- de, blank, hs, vs, line_start and frame_start are all decoded from the next-state counter values and registered. They therefore describe the same (hcount, vcount) presented in the same cycle, with zero skew.
- Mode latch: mode is loaded from mode_sel only on the en cycle where hcount == H_TOTAL-1 and vcount == V_TOTAL-1. The new totals, regions and polarities apply from the following position (0,0). mode_sel changes at any other time have no effect.
- en low freezes every output, including line_start and frame_start. Consumers qualify the markers with en.
- Reset (rst high, regardless of en):
  - mode is loaded from mode_sel.
  - hcount = H_TOTAL-1 and vcount = V_TOTAL-1 of that mode (back porch of the last line).
  - de = 0, blank = 1, hs = ~HS_POL, vs = ~VS_POL, line_start = 0, frame_start = 0.
- Reset mid-frame aborts the frame immediately; no partial sync pulse is extended.

## Timing
- Latency from rst falling edge to the first pixel is one en cycle. That cycle presents (0,0) with de = 1, frame_start = 1 and line_start = 1.
- One pixel per en cycle.
- Mode-0 line is 800 en cycles and frame is 420000. Mode-1 line is 1056 and frame is 663168.
- A mode change is visible on mode in the same cycle as the frame_start of the new frame.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst 3 cycles with mode_sel = 0 and en = 1 -> hcount = 799, vcount = 524, de = 0, blank = 1, hs = vs = 1, mode = 0. First cycle after release -> (0,0), de = 1, frame_start = 1.
- Mode-0 horizontal: run 2 lines -> hs = 0 exactly for hcount 656..751 (96 cycles), de high 640 cycles per line, line_start every 800 cycles.
- Mode-0 vertical: run 1 frame -> vs = 0 exactly for vcount 490..491 (1600 cycles), frame_start period 420000, no counter value reaches 800/525.
- en = 1 on one clock in every 4: outputs change only on en cycles and are stable otherwise; frame_start period is 1680000 clocks.
- Mode switch: set mode_sel 0->1 at vcount = 100 -> mode stays 0 until the frame ends. From the next (0,0): mode = 1, hs = 1 for hcount 840..967, line length 1056, vs = 1 for vcount 601..604. Toggling mode_sel 1->0->1 within a frame applies only the value present at the boundary.
- Reset mid-operation: assert rst at mode 1, hcount = 300, with mode_sel = 0 -> next cycle hcount = 799, vcount = 524, mode = 0, de = 0.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and the pixel pipeline.
// The generator takes the master side; consumers take the slave side.
interface vga_timing_if #(
    parameter int CW = 11
);
    logic          en;
    logic          mode_sel;
    logic          mode;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hs;
    logic          vs;
    logic          de;
    logic          blank;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en, mode_sel,
        output mode, hcount, vcount, hs, vs, de, blank, line_start, frame_start
    );

    modport slave (
        output en, mode_sel,
        input  mode, hcount, vcount, hs, vs, de, blank, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Two-mode VGA raster timing generator with frame-boundary mode switching.
// Every output is decoded from the next counter state and registered, so all outputs stay aligned.
module vga_timing_gen #(
    parameter int CW      = 11,
    parameter int H_ACT0  = 640,
    parameter int H_FP0   = 16,
    parameter int H_SYNC0 = 96,
    parameter int H_BP0   = 48,
    parameter int V_ACT0  = 480,
    parameter int V_FP0   = 10,
    parameter int V_SYNC0 = 2,
    parameter int V_BP0   = 33,
    parameter bit HS_POL0 = 1'b0,
    parameter bit VS_POL0 = 1'b0,
    parameter int H_ACT1  = 800,
    parameter int H_FP1   = 40,
    parameter int H_SYNC1 = 128,
    parameter int H_BP1   = 88,
    parameter int V_ACT1  = 600,
    parameter int V_FP1   = 1,
    parameter int V_SYNC1 = 4,
    parameter int V_BP1   = 23,
    parameter bit HS_POL1 = 1'b1,
    parameter bit VS_POL1 = 1'b1
) (
    input  logic       pixel_clk,
    input  logic       rst,
    vga_timing_if.master vt
);

    localparam logic [CW-1:0] H_LAST0  = CW'(H_ACT0 + H_FP0 + H_SYNC0 + H_BP0 - 1);
    localparam logic [CW-1:0] V_LAST0  = CW'(V_ACT0 + V_FP0 + V_SYNC0 + V_BP0 - 1);
    localparam logic [CW-1:0] H_LAST1  = CW'(H_ACT1 + H_FP1 + H_SYNC1 + H_BP1 - 1);
    localparam logic [CW-1:0] V_LAST1  = CW'(V_ACT1 + V_FP1 + V_SYNC1 + V_BP1 - 1);
    localparam logic [CW-1:0] H_ACT0_C = CW'(H_ACT0);
    localparam logic [CW-1:0] H_SB0    = CW'(H_ACT0 + H_FP0);
    localparam logic [CW-1:0] H_SE0    = CW'(H_ACT0 + H_FP0 + H_SYNC0);
    localparam logic [CW-1:0] V_ACT0_C = CW'(V_ACT0);
    localparam logic [CW-1:0] V_SB0    = CW'(V_ACT0 + V_FP0);
    localparam logic [CW-1:0] V_SE0    = CW'(V_ACT0 + V_FP0 + V_SYNC0);
    localparam logic [CW-1:0] H_ACT1_C = CW'(H_ACT1);
    localparam logic [CW-1:0] H_SB1    = CW'(H_ACT1 + H_FP1);
    localparam logic [CW-1:0] H_SE1    = CW'(H_ACT1 + H_FP1 + H_SYNC1);
    localparam logic [CW-1:0] V_ACT1_C = CW'(V_ACT1);
    localparam logic [CW-1:0] V_SB1    = CW'(V_ACT1 + V_FP1);
    localparam logic [CW-1:0] V_SE1    = CW'(V_ACT1 + V_FP1 + V_SYNC1);

    logic          mode_r, mode_n;
    logic [CW-1:0] h_r, h_n, v_r, v_n;
    logic [CW-1:0] h_last, v_last;
    logic          hs_r, vs_r, de_r, ls_r, fs_r;
    logic          hs_n, vs_n, de_n, ls_n, fs_n;
    logic [CW-1:0] h_act, hs_beg, hs_end, v_act, vs_beg, vs_end;
    logic          hs_pol, vs_pol;

    assign h_last = mode_r ? H_LAST1 : H_LAST0;
    assign v_last = mode_r ? V_LAST1 : V_LAST0;

    // Reset parks on the last pixel of the frame so the first en cycle lands on (0,0).
    always_comb begin
        mode_n = mode_r;
        h_n    = h_r;
        v_n    = v_r;
        if (rst) begin
            mode_n = vt.mode_sel;
            h_n    = vt.mode_sel ? H_LAST1 : H_LAST0;
            v_n    = vt.mode_sel ? V_LAST1 : V_LAST0;
        end else if (vt.en) begin
            if (h_r == h_last) begin
                h_n = '0;
                if (v_r == v_last) begin
                    v_n    = '0;
                    mode_n = vt.mode_sel;
                end else begin
                    v_n = v_r + 1'b1;
                end
            end else begin
                h_n = h_r + 1'b1;
            end
        end
    end

    always_comb begin
        if (mode_n) begin
            h_act  = H_ACT1_C;
            hs_beg = H_SB1;
            hs_end = H_SE1;
            v_act  = V_ACT1_C;
            vs_beg = V_SB1;
            vs_end = V_SE1;
            hs_pol = HS_POL1;
            vs_pol = VS_POL1;
        end else begin
            h_act  = H_ACT0_C;
            hs_beg = H_SB0;
            hs_end = H_SE0;
            v_act  = V_ACT0_C;
            vs_beg = V_SB0;
            vs_end = V_SE0;
            hs_pol = HS_POL0;
            vs_pol = VS_POL0;
        end
        hs_n = (h_n >= hs_beg && h_n < hs_end) ? hs_pol : ~hs_pol;
        vs_n = (v_n >= vs_beg && v_n < vs_end) ? vs_pol : ~vs_pol;
        de_n = (h_n < h_act) && (v_n < v_act);
        ls_n = (h_n == '0);
        fs_n = (h_n == '0) && (v_n == '0);
    end

    always_ff @(posedge pixel_clk) begin
        if (rst || vt.en) begin
            mode_r <= mode_n;
            h_r    <= h_n;
            v_r    <= v_n;
            hs_r   <= hs_n;
            vs_r   <= vs_n;
            de_r   <= de_n;
            ls_r   <= ls_n;
            fs_r   <= fs_n;
        end
    end

    assign vt.mode        = mode_r;
    assign vt.hcount      = h_r;
    assign vt.vcount      = v_r;
    assign vt.hs          = hs_r;
    assign vt.vs          = vs_r;
    assign vt.de          = de_r;
    assign vt.blank       = ~de_r;
    assign vt.line_start  = ls_r;
    assign vt.frame_start = fs_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen, using reduced timing sets so several whole frames fit in a short run.
// Expected outputs come from a frame-position model: a linear pixel index split into (h, v).
module tb_vga_timing_gen;
    localparam int CW  = 11;
    localparam int HA0 = 8,  HF0 = 2, HS0 = 3, HB0 = 2;
    localparam int VA0 = 5,  VF0 = 1, VS0 = 2, VB0 = 1;
    localparam int HA1 = 10, HF1 = 1, HS1 = 4, HB1 = 3;
    localparam int VA1 = 6,  VF1 = 2, VS1 = 1, VB1 = 2;
    localparam bit HP0 = 1'b0, VP0 = 1'b0, HP1 = 1'b1, VP1 = 1'b1;
    localparam int HT0 = HA0 + HF0 + HS0 + HB0;
    localparam int VT0 = VA0 + VF0 + VS0 + VB0;
    localparam int HT1 = HA1 + HF1 + HS1 + HB1;
    localparam int VT1 = VA1 + VF1 + VS1 + VB1;

    logic pixel_clk = 1'b0;
    logic rst       = 1'b1;
    always #5 pixel_clk = ~pixel_clk;

    vga_timing_if #(.CW(CW)) bus ();

    vga_timing_gen #(
        .CW(CW),
        .H_ACT0(HA0), .H_FP0(HF0), .H_SYNC0(HS0), .H_BP0(HB0),
        .V_ACT0(VA0), .V_FP0(VF0), .V_SYNC0(VS0), .V_BP0(VB0),
        .HS_POL0(HP0), .VS_POL0(VP0),
        .H_ACT1(HA1), .H_FP1(HF1), .H_SYNC1(HS1), .H_BP1(HB1),
        .V_ACT1(VA1), .V_FP1(VF1), .V_SYNC1(VS1), .V_BP1(VB1),
        .HS_POL1(HP1), .VS_POL1(VP1)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst(rst),
        .vt(bus)
    );

    typedef struct packed {
        logic          mode;
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic          hs;
        logic          vs;
        logic          de;
        logic          blank;
        logic          ls;
        logic          fs;
    } obs_t;

    typedef struct {
        logic r, e, ms;
        logic emode;
        int   eh, ev;
        logic ehs, evs, ede, els, efs;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    logic m_mode = 1'b0;
    int   m_p = 0;

    function automatic int frame_len(logic md);
        return md ? HT1 * VT1 : HT0 * VT0;
    endfunction

    function automatic obs_t expect_at(logic md, int p);
        int ha, hb, he, va, vb, ve, ht, h, v;
        logic hp, vp;
        obs_t o;
        if (md) begin
            ha = HA1; hb = HA1 + HF1; he = HA1 + HF1 + HS1; ht = HT1;
            va = VA1; vb = VA1 + VF1; ve = VA1 + VF1 + VS1; hp = HP1; vp = VP1;
        end else begin
            ha = HA0; hb = HA0 + HF0; he = HA0 + HF0 + HS0; ht = HT0;
            va = VA0; vb = VA0 + VF0; ve = VA0 + VF0 + VS0; hp = HP0; vp = VP0;
        end
        h = p % ht;
        v = p / ht;
        o.mode  = md;
        o.h     = CW'(h);
        o.v     = CW'(v);
        o.hs    = (h >= hb && h < he) ? hp : ~hp;
        o.vs    = (v >= vb && v < ve) ? vp : ~vp;
        o.de    = (h < ha) && (v < va);
        o.blank = ~o.de;
        o.ls    = (h == 0);
        o.fs    = (p == 0);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.mode  = bus.mode;
        o.h     = bus.hcount;
        o.v     = bus.vcount;
        o.hs    = bus.hs;
        o.vs    = bus.vs;
        o.de    = bus.de;
        o.blank = bus.blank;
        o.ls    = bus.line_start;
        o.fs    = bus.frame_start;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("mode=%0d h=%0d v=%0d hs=%b vs=%b de=%b blank=%b ls=%b fs=%b",
                         o.mode, o.h, o.v, o.hs, o.vs, o.de, o.blank, o.ls, o.fs);
    endfunction

    task automatic check_obs(string name, obs_t exp);
        obs_t got;
        got = sample();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t got {%s} expected {%s}", name, $time, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_step(logic r, logic e, logic ms);
        if (r) begin
            m_mode = ms;
            m_p    = frame_len(ms) - 1;
        end else if (e) begin
            m_p++;
            if (m_p == frame_len(m_mode)) begin
                m_p    = 0;
                m_mode = ms;
            end
        end
    endtask

    task automatic drive_edge(logic r, logic e, logic ms);
        rst          = r;
        bus.en       = e;
        bus.mode_sel = ms;
        @(posedge pixel_clk);
        model_step(r, e, ms);
        #1;
    endtask

    task automatic tick(logic r, logic e, logic ms);
        drive_edge(r, e, ms);
        check_obs("model", expect_at(m_mode, m_p));
    endtask

    vec_t tbl[9];

    initial begin
        int hs_low, de_cnt, vs_low, ls_cnt, early, hs_hi, vs_hi, last_fs, period;
        logic prev_fs, ms;
        obs_t exp;

        bus.en = 1'b0;
        bus.mode_sel = 1'b0;

        tbl[0] = '{1, 1, 0, 0, HT0 - 1, VT0 - 1, 1, 1, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, HT0 - 1, VT0 - 1, 1, 1, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        tbl[3] = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        tbl[4] = '{0, 1, 1, 0, 1, 0, 1, 1, 1, 0, 0};
        tbl[5] = '{1, 0, 1, 1, HT1 - 1, VT1 - 1, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        tbl[7] = '{0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0};
        tbl[8] = '{1, 1, 0, 0, HT0 - 1, VT0 - 1, 1, 1, 0, 0, 0};

        // A few reset cycles first, as the hardware would see at power-up.
        drive_edge(1, 1, 0);
        drive_edge(1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            drive_edge(tbl[i].r, tbl[i].e, tbl[i].ms);
            exp.mode  = tbl[i].emode;
            exp.h     = CW'(tbl[i].eh);
            exp.v     = CW'(tbl[i].ev);
            exp.hs    = tbl[i].ehs;
            exp.vs    = tbl[i].evs;
            exp.de    = tbl[i].ede;
            exp.blank = ~tbl[i].ede;
            exp.ls    = tbl[i].els;
            exp.fs    = tbl[i].efs;
            check_obs($sformatf("table[%0d]", i), exp);
        end

        // One full mode-0 frame: region widths.
        tick(0, 1, 0);
        hs_low = 0; de_cnt = 0; vs_low = 0; ls_cnt = 0;
        for (int i = 0; i < HT0 * VT0; i++) begin
            if (i > 0) tick(0, 1, 0);
            hs_low += (bus.hs == 1'b0) ? 1 : 0;
            vs_low += (bus.vs == 1'b0) ? 1 : 0;
            de_cnt += bus.de ? 1 : 0;
            ls_cnt += bus.line_start ? 1 : 0;
        end
        check_int("m0_hs_low_cycles", hs_low, HS0 * VT0);
        check_int("m0_vs_low_cycles", vs_low, VS0 * HT0);
        check_int("m0_de_cycles", de_cnt, HA0 * VA0);
        check_int("m0_line_starts", ls_cnt, VT0);

        // en on one clock in four: frame_start period in clocks.
        last_fs = -1; period = -1; prev_fs = bus.frame_start;
        for (int k = 0; k < 4 * HT0 * VT0 * 3 && period < 0; k++) begin
            tick(0, (k % 4) == 0, 0);
            if (bus.frame_start && !prev_fs) begin
                if (last_fs >= 0) period = k - last_fs;
                last_fs = k;
            end
            prev_fs = bus.frame_start;
        end
        check_int("en_div4_frame_period", period, 4 * HT0 * VT0);

        // Mode switch requested mid-frame, toggled, final value at boundary wins.
        tick(1, 1, 0);
        tick(0, 1, 0);
        early = 0;
        for (int i = 0; i < HT0 * VT0 - 1; i++) begin
            ms = ((m_p / HT0) >= 3 && (m_p / HT0) < 5) || (m_p / HT0) >= 7;
            tick(0, 1, ms);
            early += (bus.mode != 1'b0) ? 1 : 0;
        end
        check_int("mode_held_until_boundary", early, 0);
        tick(0, 1, 1);
        check_int("mode1_with_frame_start", {bus.mode, bus.frame_start}, 3);

        hs_hi = 0; vs_hi = 0; ls_cnt = 0;
        for (int i = 0; i < HT1 * VT1; i++) begin
            ms = !((m_p / HT1) >= 2 && (m_p / HT1) < 4);
            if (i > 0) tick(0, 1, ms);
            hs_hi += bus.hs ? 1 : 0;
            vs_hi += bus.vs ? 1 : 0;
            ls_cnt += bus.line_start ? 1 : 0;
        end
        check_int("m1_hs_high_cycles", hs_hi, HS1 * VT1);
        check_int("m1_vs_high_cycles", vs_hi, VS1 * HT1);
        check_int("m1_line_starts", ls_cnt, VT1);
        tick(0, 1, 1);
        check_int("mode1_kept", bus.mode, 1);

        // Reset in the middle of a mode-1 line with mode_sel low.
        for (int i = 0; i < 6; i++) tick(0, 1, 0);
        drive_edge(1, 1, 0);
        exp = '{1'b0, CW'(HT0 - 1), CW'(VT0 - 1), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        check_obs("mid_frame_reset", exp);

        // Random traffic against the model.
        ms = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) ms = ~ms;
            tick($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0, ms);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
